// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control tokens, the aligner state type and the offset-advance helper.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam logic [3:0] MAX_OFFSET = 4'd9;

    typedef enum logic [0:0] {
        ALIGN_SEARCH = 1'b0,
        ALIGN_LOCKED = 1'b1
    } align_state_t;

    // Slip offset steps 0..9 and wraps back to 0.
    function automatic logic [3:0] next_offset(input logic [3:0] offset);
        logic [3:0] result;
        if (offset >= MAX_OFFSET) begin
            result = 4'd0;
        end else begin
            result = offset + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tmds_control_decoder.sv
// Combinational recogniser for the four TMDS control tokens; returns {c1,c0} or zero for any other symbol.
module tmds_control_decoder
    import tmds_pkg::*;
(
    input  logic [9:0] symbol,
    output logic       is_control,
    output logic [1:0] control_value
);

    // Token match and {c1,c0} decode.
    always_comb begin
        is_control    = 1'b0;
        control_value = 2'b00;
        case (symbol)
            CTRL_TOKEN_00: begin
                is_control    = 1'b1;
                control_value = 2'b00;
            end
            CTRL_TOKEN_01: begin
                is_control    = 1'b1;
                control_value = 2'b01;
            end
            CTRL_TOKEN_10: begin
                is_control    = 1'b1;
                control_value = 2'b10;
            end
            CTRL_TOKEN_11: begin
                is_control    = 1'b1;
                control_value = 2'b11;
            end
            default: begin
                is_control    = 1'b0;
                control_value = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS symbol-boundary aligner: slips a 10-bit window over two raw words until a run of control tokens locks it.
// Optional lock-loss statistics counter enabled by defining TMDS_ALIGN_STATS_EN.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int SEARCH_WINDOW = 4096,
    parameter int CONTROL_RUN   = 8,
    parameter int LOSS_TIMEOUT  = 8192
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       raw_valid,
    input  logic [9:0] raw_word,
    output logic       aligned_valid,
    output logic [9:0] aligned_word,
    output logic       is_control,
    output logic [1:0] control_value,
    output logic       locked,
    output logic [3:0] bit_offset
`ifdef TMDS_ALIGN_STATS_EN
    ,
    output logic [15:0] lock_loss_count
`endif
);

    localparam int DWELL_W = $clog2(SEARCH_WINDOW) + 1;
    localparam int RUN_W   = $clog2(CONTROL_RUN) + 1;
    localparam int TMO_W   = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [DWELL_W-1:0] DWELL_LIMIT = DWELL_W'(SEARCH_WINDOW);
    localparam logic [RUN_W-1:0]   RUN_LIMIT   = RUN_W'(CONTROL_RUN);
    localparam logic [TMO_W-1:0]   TMO_LIMIT   = TMO_W'(LOSS_TIMEOUT);
    localparam logic [DWELL_W-1:0] DWELL_ONE   = DWELL_W'(1);
    localparam logic [RUN_W-1:0]   RUN_ONE     = RUN_W'(1);
    localparam logic [TMO_W-1:0]   TMO_ONE     = TMO_W'(1);

    logic [9:0]         prev_word_r;
    logic [19:0]        concat_s;
    logic [9:0]         window_s;
    logic               win_is_control_s;
    logic [1:0]         win_control_value_s;

    align_state_t       state_r;
    align_state_t       state_nxt_s;
    logic [3:0]         offset_r;
    logic [3:0]         offset_nxt_s;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] dwell_nxt_s;
    logic [DWELL_W-1:0] dwell_inc_s;
    logic [RUN_W-1:0]   run_r;
    logic [RUN_W-1:0]   run_nxt_s;
    logic [RUN_W-1:0]   run_inc_s;
    logic [TMO_W-1:0]   timeout_r;
    logic [TMO_W-1:0]   timeout_nxt_s;
    logic [TMO_W-1:0]   timeout_inc_s;

    logic               aligned_valid_r;
    logic [9:0]         aligned_word_r;
    logic               is_control_r;
    logic [1:0]         control_value_r;

    assign concat_s = {raw_word, prev_word_r};

    // 20->10 barrel select; bit 0 of the window is the earliest received bit at this offset.
    always_comb begin
        window_s = concat_s[9:0];
        case (offset_r)
            4'd0:    window_s = concat_s[9:0];
            4'd1:    window_s = concat_s[10:1];
            4'd2:    window_s = concat_s[11:2];
            4'd3:    window_s = concat_s[12:3];
            4'd4:    window_s = concat_s[13:4];
            4'd5:    window_s = concat_s[14:5];
            4'd6:    window_s = concat_s[15:6];
            4'd7:    window_s = concat_s[16:7];
            4'd8:    window_s = concat_s[17:8];
            4'd9:    window_s = concat_s[18:9];
            default: window_s = concat_s[9:0];
        endcase
    end

    tmds_control_decoder u_ctrl_dec (
        .symbol        (window_s),
        .is_control    (win_is_control_s),
        .control_value (win_control_value_s)
    );

    assign dwell_inc_s   = (dwell_r   >= DWELL_LIMIT) ? dwell_r   : dwell_r   + DWELL_ONE;
    assign run_inc_s     = (run_r     >= RUN_LIMIT)   ? run_r     : run_r     + RUN_ONE;
    assign timeout_inc_s = (timeout_r >= TMO_LIMIT)   ? timeout_r : timeout_r + TMO_ONE;

    // Next-state logic: everything holds unless a valid beat arrives; lock beats offset advance.
    always_comb begin
        state_nxt_s   = state_r;
        offset_nxt_s  = offset_r;
        dwell_nxt_s   = dwell_r;
        run_nxt_s     = run_r;
        timeout_nxt_s = timeout_r;
        if (raw_valid) begin
            case (state_r)
                ALIGN_SEARCH: begin
                    dwell_nxt_s = dwell_inc_s;
                    run_nxt_s   = win_is_control_s ? run_inc_s : {RUN_W{1'b0}};
                    if (run_nxt_s >= RUN_LIMIT) begin
                        state_nxt_s   = ALIGN_LOCKED;
                        timeout_nxt_s = {TMO_W{1'b0}};
                    end else if (dwell_nxt_s >= DWELL_LIMIT) begin
                        state_nxt_s  = ALIGN_SEARCH;
                        offset_nxt_s = next_offset(offset_r);
                        dwell_nxt_s  = {DWELL_W{1'b0}};
                        run_nxt_s    = {RUN_W{1'b0}};
                    end else begin
                        state_nxt_s = ALIGN_SEARCH;
                    end
                end
                ALIGN_LOCKED: begin
                    timeout_nxt_s = win_is_control_s ? {TMO_W{1'b0}} : timeout_inc_s;
                    if (timeout_nxt_s >= TMO_LIMIT) begin
                        state_nxt_s   = ALIGN_SEARCH;
                        dwell_nxt_s   = {DWELL_W{1'b0}};
                        run_nxt_s     = {RUN_W{1'b0}};
                        timeout_nxt_s = {TMO_W{1'b0}};
                    end else begin
                        state_nxt_s = ALIGN_LOCKED;
                    end
                end
                default: begin
                    state_nxt_s   = ALIGN_SEARCH;
                    offset_nxt_s  = 4'd0;
                    dwell_nxt_s   = {DWELL_W{1'b0}};
                    run_nxt_s     = {RUN_W{1'b0}};
                    timeout_nxt_s = {TMO_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counter, previous-word and output registers.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_r         <= ALIGN_SEARCH;
            offset_r        <= 4'd0;
            dwell_r         <= {DWELL_W{1'b0}};
            run_r           <= {RUN_W{1'b0}};
            timeout_r       <= {TMO_W{1'b0}};
            prev_word_r     <= 10'd0;
            aligned_valid_r <= 1'b0;
            aligned_word_r  <= 10'd0;
            is_control_r    <= 1'b0;
            control_value_r <= 2'b00;
        end else begin
            state_r   <= state_nxt_s;
            offset_r  <= offset_nxt_s;
            dwell_r   <= dwell_nxt_s;
            run_r     <= run_nxt_s;
            timeout_r <= timeout_nxt_s;
            if (raw_valid) begin
                prev_word_r     <= raw_word;
                aligned_valid_r <= 1'b1;
                aligned_word_r  <= window_s;
                is_control_r    <= win_is_control_s;
                control_value_r <= win_control_value_s;
            end else begin
                aligned_valid_r <= 1'b0;
            end
        end
    end

    assign aligned_valid = aligned_valid_r;
    assign aligned_word  = aligned_word_r;
    assign is_control    = is_control_r;
    assign control_value = control_value_r;
    assign locked        = (state_r == ALIGN_LOCKED);
    assign bit_offset    = offset_r;

`ifdef TMDS_ALIGN_STATS_EN
    logic [15:0] loss_count_r;

    // Saturating count of LOCKED->SEARCH transitions.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            loss_count_r <= 16'd0;
        end else if ((state_r == ALIGN_LOCKED) && (state_nxt_s == ALIGN_SEARCH)
                     && (loss_count_r != 16'hFFFF)) begin
            loss_count_r <= loss_count_r + 16'd1;
        end else begin
            loss_count_r <= loss_count_r;
        end
    end

    assign lock_loss_count = loss_count_r;
`endif

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Self-checking bench for tmds_word_aligner: vector table, directed multi-cycle sequences, randomized model check.
module tb_tmds_word_aligner;

    localparam int SW = 16;
    localparam int CR = 8;
    localparam int LT = 32;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic       raw_valid;
    logic [9:0] raw_word;
    logic       aligned_valid;
    logic [9:0] aligned_word;
    logic       is_control;
    logic [1:0] control_value;
    logic       locked;
    logic [3:0] bit_offset;
`ifdef TMDS_ALIGN_STATS_EN
    logic [15:0] lock_loss_count;
`endif

    tmds_word_aligner #(
        .SEARCH_WINDOW (SW),
        .CONTROL_RUN   (CR),
        .LOSS_TIMEOUT  (LT)
    ) dut (
        .clk_pixel     (clk_pixel),
        .reset         (reset),
        .raw_valid     (raw_valid),
        .raw_word      (raw_word),
        .aligned_valid (aligned_valid),
        .aligned_word  (aligned_word),
        .is_control    (is_control),
        .control_value (control_value),
        .locked        (locked),
        .bit_offset    (bit_offset)
`ifdef TMDS_ALIGN_STATS_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks   = 0;
    int failures = 0;

    logic [9:0] tok [4];
    localparam logic [9:0] DATA_WORD = 10'b0111110000;

    // Reference model state: bit-stream view of the aligner.
    logic [9:0] m_prev, m_word;
    int         m_off, m_run, m_dwell, m_tmo, m_llc;
    bit         m_locked, m_av, m_ic;
    logic [1:0] m_cv;

    typedef struct {
        bit         rst;
        bit         v;
        logic [9:0] w;
        bit         e_av;
        logic [9:0] e_word;
        bit         e_ic;
        logic [1:0] e_cv;
        bit         e_lock;
        logic [3:0] e_off;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input logic [9:0] w);
        logic [19:0] cat;
        logic [9:0]  win;
        int          code;
        if (rst) begin
            m_prev = 10'd0; m_word = 10'd0; m_off = 0; m_run = 0; m_dwell = 0; m_tmo = 0;
            m_llc = 0; m_locked = 1'b0; m_av = 1'b0; m_ic = 1'b0; m_cv = 2'b00;
        end else if (v) begin
            cat  = {w, m_prev};
            win  = 10'(cat >> m_off);
            code = -1;
            for (int i = 0; i < 4; i++) if (win == tok[i]) code = i;
            m_av   = 1'b1;
            m_word = win;
            m_ic   = (code >= 0);
            m_cv   = (code >= 0) ? 2'(code) : 2'b00;
            m_prev = w;
            if (!m_locked) begin
                m_dwell++;
                m_run = m_ic ? m_run + 1 : 0;
                if (m_run >= CR) begin
                    m_locked = 1'b1;
                    m_tmo    = 0;
                end else if (m_dwell >= SW) begin
                    m_off   = (m_off + 1) % 10;
                    m_dwell = 0;
                    m_run   = 0;
                end
            end else begin
                m_tmo = m_ic ? 0 : m_tmo + 1;
                if (m_tmo >= LT) begin
                    m_locked = 1'b0;
                    m_dwell  = 0;
                    m_run    = 0;
                    m_tmo    = 0;
                    if (m_llc < 65535) m_llc++;
                end
            end
        end else begin
            m_av = 1'b0;
        end
    endtask

    task automatic cyc(input bit rst, input bit v, input logic [9:0] w);
        reset     = rst;
        raw_valid = v;
        raw_word  = w;
        model_step(rst, v, w);
        @(posedge clk_pixel);
        #1;
        chk("m_valid",   32'(aligned_valid), 32'(m_av));
        chk("m_word",    32'(aligned_word),  32'(m_word));
        chk("m_is_ctrl", 32'(is_control),    32'(m_ic));
        chk("m_cv",      32'(control_value), 32'(m_cv));
        chk("m_locked",  32'(locked),        32'(m_locked));
        chk("m_offset",  32'(bit_offset),    32'(m_off));
`ifdef TMDS_ALIGN_STATS_EN
        chk("m_llc",     32'(lock_loss_count), 32'(m_llc));
`endif
    endtask

    // Token bit stream delayed by d bits, cut into 10-bit words (bit 0 first on the wire).
    function automatic logic [9:0] delayed(input logic [9:0] t, input int d);
        logic [9:0] r;
        for (int j = 0; j < 10; j++) r[j] = t[(j + 10 - d) % 10];
        return r;
    endfunction

    initial begin
        logic [9:0] w3;
        logic [9:0] wr;
        int         d;
        int         t;

        tok[0] = 10'b1101010100;
        tok[1] = 10'b0010101011;
        tok[2] = 10'b0101010100;
        tok[3] = 10'b1010101011;
        reset = 1'b1; raw_valid = 1'b1; raw_word = 10'h3FF;

        // Tests 1 and 2: reset with busy inputs, then continuous 00 tokens at offset 0.
        for (int i = 0; i < 12; i++) begin
            if (i < 3)
                tbl[i] = '{1'b1, 1'b1, 10'h3FF, 1'b0, 10'h000, 1'b0, 2'b00, 1'b0, 4'd0};
            else if (i == 3)
                tbl[i] = '{1'b0, 1'b1, tok[0], 1'b1, 10'h000, 1'b0, 2'b00, 1'b0, 4'd0};
            else
                tbl[i] = '{1'b0, 1'b1, tok[0], 1'b1, tok[0], 1'b1, 2'b00, (i == 11), 4'd0};
        end
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].rst, tbl[i].v, tbl[i].w);
            chk("tbl_valid",   32'(aligned_valid), 32'(tbl[i].e_av));
            chk("tbl_word",    32'(aligned_word),  32'(tbl[i].e_word));
            chk("tbl_is_ctrl", 32'(is_control),    32'(tbl[i].e_ic));
            chk("tbl_cv",      32'(control_value), 32'(tbl[i].e_cv));
            chk("tbl_locked",  32'(locked),        32'(tbl[i].e_lock));
            chk("tbl_offset",  32'(bit_offset),    32'(tbl[i].e_off));
        end

        // Test 3: 01 tokens delayed by 3 bits; search steps offsets every 16 beats.
        w3 = delayed(tok[1], 3);
        cyc(1'b1, 1'b0, 10'd0);
        for (int b = 1; b <= 56; b++) begin
            cyc(1'b0, 1'b1, w3);
            if (b == 15) chk("t3_off_b15", 32'(bit_offset), 32'd0);
            if (b == 16 || b == 32 || b == 48) chk("t3_off_step", 32'(bit_offset), 32'(b / 16));
            if (b == 55) chk("t3_not_yet", 32'(locked), 32'd0);
        end
        chk("t3_locked", 32'(locked),        32'd1);
        chk("t3_offset", 32'(bit_offset),    32'd3);
        chk("t3_word",   32'(aligned_word),  32'(10'b0010101011));
        chk("t3_cv",     32'(control_value), 32'd1);

        // Test 4: data words until the loss timeout expires.
        for (int b = 1; b <= 32; b++) begin
            cyc(1'b0, 1'b1, DATA_WORD);
            if (b == 31) chk("t4_still_locked", 32'(locked), 32'd1);
        end
        chk("t4_unlocked", 32'(locked),     32'd0);
        chk("t4_offset",   32'(bit_offset), 32'd3);
`ifdef TMDS_ALIGN_STATS_EN
        chk("t4_llc", 32'(lock_loss_count), 32'd1);
`endif

        // Relock at offset 3, then a one-cycle reset while locked.
        for (int b = 1; b <= 10; b++) cyc(1'b0, 1'b1, w3);
        chk("t6_relock3", 32'(locked), 32'd1);
        cyc(1'b1, 1'b1, tok[0]);
        chk("t6_rst_locked", 32'(locked),     32'd0);
        chk("t6_rst_offset", 32'(bit_offset), 32'd0);
        // First window after reset still holds the cleared previous word, so 8 token windows take 9 beats.
        for (int b = 1; b <= 9; b++) begin
            cyc(1'b0, 1'b1, tok[0]);
            if (b == 8) chk("t6_not_yet", 32'(locked), 32'd0);
        end
        chk("t6_relocked", 32'(locked), 32'd1);

        // Test 5: raw_valid toggling every cycle after one priming beat.
        cyc(1'b1, 1'b0, 10'd0);
        cyc(1'b0, 1'b1, tok[0]);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, (i % 2) == 0, tok[0]);
            if (i == 1)  chk("t5_gap_valid", 32'(aligned_valid), 32'd0);
            if (i == 12) chk("t5_not_yet",   32'(locked),        32'd0);
            if (i == 14) chk("t5_locked",    32'(locked),        32'd1);
        end
        chk("t5_gap_valid_end", 32'(aligned_valid), 32'd0);
        chk("t5_lock_holds",    32'(locked),        32'd1);

        // Randomized episodes: random token and delay, random valid gaps, then random data.
        for (int ep = 0; ep < 6; ep++) begin
            cyc(1'b1, 1'b0, 10'd0);
            d  = $urandom_range(0, 9);
            t  = $urandom_range(0, 3);
            wr = delayed(tok[t], d);
            for (int c = 0; c < 300; c++) cyc(1'b0, $urandom_range(0, 3) != 0, wr);
            for (int c = 0; c < 120; c++) cyc(1'b0, $urandom_range(0, 3) != 0, 10'($urandom));
            if ($urandom_range(0, 1) == 1) cyc(1'b1, 1'b1, wr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
